// File: rtl/lcd_fifo_rd_ctl.sv
// LCD read-side raster controller: waits for frame sync and a FIFO prefill level,
// then produces HSYNC/VSYNC/DE timing and pops one FIFO word per active pixel.
module lcd_fifo_rd_ctl #(
  parameter int          H_ACTIVE           = 800,
  parameter int          H_FP               = 40,
  parameter int          H_SYNC             = 128,
  parameter int          H_BP               = 88,
  parameter int          V_ACTIVE           = 480,
  parameter int          V_FP               = 1,
  parameter int          V_SYNC             = 3,
  parameter int          V_BP               = 21,
  parameter logic [31:0] FIFO_PREFILL_DEPTH = 32'd512
) (
  input  logic        fifo_rd_clk,
  input  logic        rst_n,
  input  logic        lcd_framesync,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_rd_data,
  input  logic        fifo_empty,
  input  logic [9:0]  fifo_rd_cnt,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        underflow,
  output logic [1:0]  o_dbg_state
);

  localparam logic [11:0] H_SYNC_W  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_W  = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_LO  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_HI  = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_ACT_LO  = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_HI  = 12'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] H_LAST    = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [11:0] V_LAST    = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t      r_state;
  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        r_rd_d;
  logic        r_underflow;
  logic        r_frame_err;

  logic w_h_act;
  logic w_v_act;
  logic w_active_pre;
  logic w_rd_en;
  logic w_underrun;
  logic w_h_last;
  logic w_v_last;
  logic w_prefill_ok;

  assign w_h_act      = (r_h_cnt >= H_ACT_LO) && (r_h_cnt < H_ACT_HI);
  assign w_v_act      = (r_v_cnt >= V_ACT_LO) && (r_v_cnt < V_ACT_HI);
  assign w_active_pre = (r_state == ST_RUN) && w_h_act && w_v_act;
  assign w_rd_en      = w_active_pre && !fifo_empty;
  assign w_underrun   = w_active_pre && fifo_empty;
  assign w_h_last     = (r_h_cnt == H_LAST);
  assign w_v_last     = (r_v_cnt == V_LAST);
  assign w_prefill_ok = ({22'd0, fifo_rd_cnt} >= FIFO_PREFILL_DEPTH);

  always_ff @(posedge fifo_rd_clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_h_cnt     <= 12'd0;
      r_v_cnt     <= 12'd0;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_de        <= 1'b0;
      r_rd_d      <= 1'b0;
      r_underflow <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
      r_de   <= 1'b0;
      r_rd_d <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_h_cnt <= 12'd0;
          r_v_cnt <= 12'd0;
          if (lcd_framesync) r_state <= ST_PREFILL;
        end
        ST_PREFILL: begin
          r_h_cnt <= 12'd0;
          r_v_cnt <= 12'd0;
          if (w_prefill_ok) r_state <= ST_RUN;
        end
        ST_RUN: begin
          // Outputs lag the counters by one clock to line up with FIFO read data.
          r_hs   <= !(r_h_cnt < H_SYNC_W);
          r_vs   <= !(r_v_cnt < V_SYNC_W);
          r_de   <= w_active_pre;
          r_rd_d <= w_rd_en;
          if (w_underrun) begin
            r_underflow <= 1'b1;
            r_frame_err <= 1'b1;
          end
          if (w_h_last) begin
            r_h_cnt <= 12'd0;
            if (w_v_last) begin
              r_v_cnt <= 12'd0;
              // A damaged frame drops back to IDLE to resynchronise with the writer.
              if (r_frame_err || w_underrun) begin
                r_state     <= ST_IDLE;
                r_frame_err <= 1'b0;
              end
            end else begin
              r_v_cnt <= r_v_cnt + 12'd1;
            end
          end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_rd_en  = w_rd_en;
  assign lcd_hs      = r_hs;
  assign lcd_vs      = r_vs;
  assign lcd_de      = r_de;
  assign lcd_rgb     = r_rd_d ? fifo_rd_data : 16'h0000;
  assign underflow   = r_underflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lcd_fifo_rd_ctl.sv
// Bench for lcd_fifo_rd_ctl with a small raster; a model FIFO supplies pixels and
// a scoreboard queue holds the pixel values expected on lcd_de cycles.
module tb_lcd_fifo_rd_ctl;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PREFILL = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lcd_framesync;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data = 16'h0000;
  logic        fifo_empty;
  logic [9:0]  fifo_rd_cnt;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [15:0] lcd_rgb;
  logic        underflow;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];

  // Model FIFO
  logic [15:0] mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic        force_empty = 1'b0;
  logic        flush = 1'b0;

  int n_de = 0, n_hs_low = 0, n_vs_low = 0, n_pop = 0;

  always #5 clk = ~clk;

  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  lcd_fifo_rd_ctl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FIFO_PREFILL_DEPTH(32'd8)
  ) dut (
    .fifo_rd_clk  (clk),
    .rst_n        (rst_n),
    .lcd_framesync(lcd_framesync),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_cnt  (fifo_rd_cnt),
    .lcd_hs       (lcd_hs),
    .lcd_vs       (lcd_vs),
    .lcd_de       (lcd_de),
    .lcd_rgb      (lcd_rgb),
    .underflow    (underflow),
    .o_dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic preload(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = 16'(first + i);
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 8'd1;
    end
  end

  // Monitor: samples shortly after each edge, well away from the next one.
  always @(posedge clk) begin
    #2;
    check("rd_en_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
    if (fifo_rd_en) n_pop++;
    if (!lcd_hs) n_hs_low++;
    if (!lcd_vs) n_vs_low++;
    if (lcd_de) begin
      n_de++;
      check("exp_q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("rgb", {16'd0, lcd_rgb}, {16'd0, exp_q.pop_front()});
    end else begin
      check("rgb_blank", {16'd0, lcd_rgb}, 32'd0);
    end
  end

  task automatic frame_stats(input string tag, input int de0, input int hs0, input int vs0,
                             input int pop0, input int exp_pop);
    check({tag, "_de_count"},  32'(n_de - de0),       32'd12);
    check({tag, "_hs_low"},    32'(n_hs_low - hs0),   32'd12);
    check({tag, "_vs_low"},    32'(n_vs_low - vs0),   32'd8);
    check({tag, "_pop_count"}, 32'(n_pop - pop0),     32'(exp_pop));
  endtask

  initial begin
    int bad;
    int cyc;
    int de0, hs0, vs0, pop0;
    rst_n = 1'b0;
    lcd_framesync = 1'b0;
    fifo_rd_cnt = 10'd0;
    repeat (3) @(negedge clk);
    check("rst_hs", {31'd0, lcd_hs}, 32'd1);
    check("rst_vs", {31'd0, lcd_vs}, 32'd1);
    check("rst_de", {31'd0, lcd_de}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_underflow", {31'd0, underflow}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    rst_n = 1'b1;

    // No framesync: stay idle even with a full FIFO.
    fifo_rd_cnt = 10'd20;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!lcd_hs || !lcd_vs || lcd_de || fifo_rd_en || dbg_state != S_IDLE) bad++;
    end
    check("idle_hold", 32'(bad), 32'd0);

    // Two clean frames then a third with an underflow at pixel 6.
    preload(1, 36);
    for (int i = 1; i <= 24; i++) exp_q.push_back(16'(i));
    for (int i = 25; i <= 29; i++) exp_q.push_back(16'(i));
    exp_q.push_back(16'h0000);
    for (int i = 30; i <= 35; i++) exp_q.push_back(16'(i));

    fifo_rd_cnt = 10'd5;
    lcd_framesync = 1'b1;
    @(negedge clk);
    lcd_framesync = 1'b0;
    check("fs_to_prefill", {30'd0, dbg_state}, {30'd0, S_PREFILL});
    repeat (10) @(negedge clk);
    check("prefill_hold", {30'd0, dbg_state}, {30'd0, S_PREFILL});
    fifo_rd_cnt = 10'd8;
    @(negedge clk);
    check("prefill_to_run", {30'd0, dbg_state}, {30'd0, S_RUN});
    de0 = n_de; hs0 = n_hs_low; vs0 = n_vs_low; pop0 = n_pop;
    cyc = 0;
    while (!lcd_de && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("first_de_latency", 32'(cyc), 32'd20);
    repeat (48 - cyc) @(negedge clk);
    frame_stats("frame1", de0, hs0, vs0, pop0, 12);

    de0 = n_de; hs0 = n_hs_low; vs0 = n_vs_low; pop0 = n_pop;
    repeat (10) @(negedge clk);
    lcd_framesync = 1'b1;
    @(negedge clk);
    lcd_framesync = 1'b0;
    repeat (37) @(negedge clk);
    frame_stats("frame2", de0, hs0, vs0, pop0, 12);
    check("frame2_state", {30'd0, dbg_state}, {30'd0, S_RUN});
    check("frame2_underflow", {31'd0, underflow}, 32'd0);

    de0 = n_de; hs0 = n_hs_low; vs0 = n_vs_low; pop0 = n_pop;
    repeat (28) @(negedge clk);
    force_empty = 1'b1;
    #1;
    check("uf_no_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    force_empty = 1'b0;
    check("uf_flag", {31'd0, underflow}, 32'd1);
    check("uf_de", {31'd0, lcd_de}, 32'd1);
    check("uf_rgb", {16'd0, lcd_rgb}, 32'd0);
    repeat (19) @(negedge clk);
    frame_stats("frame3", de0, hs0, vs0, pop0, 11);
    check("uf_to_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    repeat (20) @(negedge clk);
    check("uf_idle_hold", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("uf_sticky", {31'd0, underflow}, 32'd1);
    check("uf_exp_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of an active line.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    preload(101, 12);
    exp_q.push_back(16'd101);
    lcd_framesync = 1'b1;
    @(negedge clk);
    lcd_framesync = 1'b0;
    @(negedge clk);
    check("rst_test_run", {30'd0, dbg_state}, {30'd0, S_RUN});
    repeat (20) @(negedge clk);
    check("pre_rst_de", {31'd0, lcd_de}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_de", {31'd0, lcd_de}, 32'd0);
    check("midrst_hs", {31'd0, lcd_hs}, 32'd1);
    check("midrst_vs", {31'd0, lcd_vs}, 32'd1);
    check("midrst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("midrst_underflow", {31'd0, underflow}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("post_rst_exp_drained", 32'(exp_q.size()), 32'd0);

    // Framesync coincident with reset is dropped.
    rst_n = 1'b0;
    lcd_framesync = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    lcd_framesync = 1'b0;
    @(negedge clk);
    check("fs_with_rst", {30'd0, dbg_state}, {30'd0, S_IDLE});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_fifo_rd_ctl.md
# lcd_fifo_rd_ctl

Read-side controller of the LCD pixel FIFO: generates LCD raster timing (HSYNC/VSYNC/DE), pops one FIFO word per active pixel and drives it to the panel. Counterpart of the FIFO write controller, which fills the FIFO from the AXI stream and forwards the frame-sync pulse. The block waits for frame sync and a FIFO prefill level before starting raster output, and detects FIFO underflow.

## Interface
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, HSYNC width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, VSYNC width (lines)
- V_BP, 21, vertical back porch (lines)
- FIFO_PREFILL_DEPTH, 32'd512, FIFO level required before raster starts
- fifo_rd_clk  input  1  pixel clock; FIFO read clock
- rst_n  input  1  synchronous active-low reset
- lcd_framesync  input  1  frame-start pulse from write side (one clock, synchronous to fifo_rd_clk)
- fifo_rd_en  output  1  FIFO read enable
- fifo_rd_data  input  16  FIFO read data, valid one clock after fifo_rd_en (RGB565)
- fifo_empty  input  1  FIFO empty, active high
- fifo_rd_cnt  input  10  FIFO fill level
- lcd_hs  output  1  HSYNC, active low
- lcd_vs  output  1  VSYNC, active low
- lcd_de  output  1  data enable, active high
- lcd_rgb  output  16  pixel data
- underflow  output  1  sticky underflow flag

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP. h_cnt, v_cnt 12 bits each, unsigned.
- Line order: sync, back porch, active, front porch; same for frame in lines.
- States: IDLE, PREFILL, RUN.
  - IDLE: counters held 0; lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_rgb=0, fifo_rd_en=0. lcd_framesync=1 -> PREFILL.
  - PREFILL: outputs as IDLE. fifo_rd_cnt >= FIFO_PREFILL_DEPTH -> RUN with h_cnt=v_cnt=0.
  - RUN: h_cnt increments every clock, wraps H_TOTAL-1 -> 0 and increments v_cnt; v_cnt wraps V_TOTAL-1 -> 0. lcd_framesync ignored.
- Frame end (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1): if frame_err set -> IDLE, frame_err cleared; else stay RUN, next frame starts immediately.
- active_pre = RUN && h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) && v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- fifo_rd_en = active_pre && !fifo_empty (combinational). Never asserted while fifo_empty=1.
- Underflow: active_pre && fifo_empty -> no pop; that pixel outputs lcd_rgb=16'h0000 with lcd_de=1; underflow set (sticky until reset); frame_err set for the current frame.
- Reset: state IDLE, counters 0, underflow=0, frame_err=0; all outputs at IDLE values.

## Timing
- lcd_hs, lcd_vs, lcd_de, lcd_rgb registered; aligned one clock after the counter value generating them, matching the FIFO's 1-clock read latency.
- lcd_hs(t+1) = !(h_cnt(t) < H_SYNC); lcd_vs(t+1) = !(v_cnt(t) < V_SYNC); lcd_de(t+1) = active_pre(t).
- lcd_rgb(t+1) = fifo_rd_data (returned for rd_en at t) when rd_en(t)=1; 0 otherwise.
- framesync to PREFILL: 1 clock. PREFILL to RUN: 1 clock after fill condition true. First lcd_de high at (H_SYNC+H_BP) + (V_SYNC+V_BP)*H_TOTAL + 1 clocks after entering RUN.
- framesync in PREFILL or RUN: no effect. framesync coincident with reset: reset wins.
- Reset mid-frame: outputs to IDLE values on the next clock edge; partial line not completed.
- Exactly H_ACTIVE*V_ACTIVE pops per clean frame.

## Test plan
- Bench parameters H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, FIFO_PREFILL_DEPTH=8 (H_TOTAL=8, V_TOTAL=6).
- Reset then no framesync, fifo_rd_cnt=20 -> stays IDLE, lcd_hs=lcd_vs=1, lcd_de=0, fifo_rd_en=0 for 200 clocks.
- framesync with fifo_rd_cnt=5, raised to 8 after 10 clocks -> RUN entered 1 clock later; first lcd_de at clock 3+2*8+1=20 after RUN entry.
- Model FIFO with 1..12 preloaded -> lcd_rgb sequence 1..12 exactly on lcd_de cycles, 4 per line, lcd_hs low 2 clocks/line, lcd_vs low 8 clocks/frame, 12 pops per frame, second frame continues seamlessly.
- Force fifo_empty=1 at 6th active pixel -> fifo_rd_en stays 0, lcd_rgb=0 with lcd_de=1 on that pixel, underflow=1 and stays 1; after frame end state IDLE until next framesync.
- Assert rst_n=0 mid-active-line -> next clock lcd_de=0, lcd_hs=lcd_vs=1, fifo_rd_en=0, underflow=0; block waits for framesync.
